pwm_mix_engine: RTL and testbench

PWM_MIX_ENGINE -- requirements
Module: pwm_mix_engine

---
 rtl/pwm_mix_pkg.sv | 26 ++
 rtl/pwm_mix_engine_seq_divider.sv | 72 +++++++
 rtl/pwm_mix_engine.sv | 151 +++++++++++++++
 tb/tb_pwm_mix_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_mix_pkg.sv
// Shared definitions for the PWM mix engine: mix modes, FSM states and the
// SHIFT-mode shift selector.
package pwm_mix_pkg;

  typedef enum logic [1:0] {
    MODE_NORM  = 2'd0,
    MODE_SAT   = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_RSVD  = 2'd3   // behaves like MODE_NORM
  } mix_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mix_state_e;

  // Shift applied in SHIFT mode: 0 for one channel, otherwise clog2(k).
  // This gives 1 for k=2, 2 for k=3..4, 3 for k=5..8 and 4 for k=9..16.
  function automatic int unsigned shift_sel(input int unsigned k);
    if (k <= 1) return 0;
    return unsigned'($clog2(k));
  endfunction

endpackage

// File: rtl/pwm_mix_engine_seq_divider.sv
// SW-bit restoring divider, one quotient bit per cycle.
// Handshake: a one-cycle 'start' pulse loads dividend/divisor; 'done' pulses
// for one cycle SW cycles later, and 'quotient' holds its value until the
// next start. A start while a division is running restarts it.
module seq_divider #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          done,
  output logic [SW-1:0] quotient
);

  localparam int CNTW = $clog2(SW + 1);

  logic [SW-1:0]   rem_q;
  logic [SW-1:0]   quo_q;
  logic [SW-1:0]   dvs_q;
  logic [CNTW-1:0] cnt_q;
  logic            run_q;
  logic            done_q;

  logic [SW:0]     trial;
  logic            ge;
  logic [SW-1:0]   rem_nxt;
  logic [SW-1:0]   quo_nxt;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits.
  always_comb begin
    trial   = {rem_q, quo_q[SW-1]};
    ge      = (trial >= {1'b0, dvs_q});
    rem_nxt = ge ? (trial[SW-1:0] - dvs_q) : trial[SW-1:0];
    quo_nxt = {quo_q[SW-2:0], ge};
  end

  // Iteration registers and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= divisor;
        cnt_q <= CNTW'(SW);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/pwm_mix_engine.sv
// PWM mix engine: snapshots N_CH duty values at the start of each PWM period,
// mixes the enabled ones (average / saturating sum / shifted sum) and applies
// the result to the PWM output for the following period.
module pwm_mix_engine
  import pwm_mix_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 6
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] duty_in,
  input  logic [N_CH-1:0]   en,
  input  logic [1:0]        mode,
  output logic              pwm,
  output logic [W-1:0]      duty_act,
  output logic              period_start,
  output logic              busy,
  output mix_state_e        fsm_state
);

  localparam int SW = W + $clog2(N_CH);
  localparam int KW = $clog2(N_CH + 1);
  localparam int CW = $clog2(N_CH);
  localparam logic [W-1:0]  CNT_MAX = '1;
  localparam logic [SW-1:0] SAT_MAX = SW'((1 << W) - 1);

  // The whole mix must finish inside one period, and the channel count is bounded.
  if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
    $fatal(1, "pwm_mix_engine: N_CH must be in 2..16");
  end
  if ((1 << W) < N_CH + SW + 4) begin : g_bad_w
    $fatal(1, "pwm_mix_engine: period 2^W too short for N_CH + SW + 4 cycles");
  end

  logic [W-1:0]      count;
  logic [N_CH*W-1:0] duty_sh;
  logic [N_CH-1:0]   en_sh;
  mix_mode_e         mode_sh;
  logic [SW-1:0]     sum_q;
  logic [KW-1:0]     k_q;
  logic [CW-1:0]     ch_q;
  logic [W-1:0]      result_q;
  mix_state_e        state_q;
  mix_state_e        state_d;

  logic              snap;
  logic              acc_last;
  logic              is_norm;
  logic [W-1:0]      cur_duty;
  logic              cur_en;
  logic [SW-1:0]     sum_nxt;
  logic [KW-1:0]     k_nxt;
  logic [SW-1:0]     shifted;
  logic [W-1:0]      direct_res;
  logic              div_start;
  logic              div_done;
  logic [SW-1:0]     div_quo;
  logic              div_quo_unused;

  assign snap           = (state_q == ST_IDLE) && (count == '0);
  assign acc_last       = (state_q == ST_ACC) && (ch_q == CW'(N_CH - 1));
  assign is_norm        = (mode_sh != MODE_SAT) && (mode_sh != MODE_SHIFT);
  assign period_start   = (count == '0);
  assign pwm            = (count < duty_act);
  assign busy           = (state_q != ST_IDLE);
  assign fsm_state      = state_q;
  // sum/k never exceeds the largest duty, so the upper quotient bits are zero.
  assign div_quo_unused = ^div_quo[SW-1:W];

  // Free-running period counter.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count + 1'b1;
  end

  // Per-channel accumulation and the non-dividing mix results.
  always_comb begin
    cur_duty   = duty_sh[int'(ch_q) * W +: W];
    cur_en     = en_sh[ch_q];
    sum_nxt    = sum_q + (cur_en ? SW'(cur_duty) : '0);
    k_nxt      = k_q + KW'(cur_en);
    div_start  = acc_last && is_norm && (k_nxt != '0);
    shifted    = sum_q >> shift_sel(32'(k_q));
    direct_res = '0;
    if (k_q != '0) begin
      if (mode_sh == MODE_SAT) direct_res = (sum_q > SAT_MAX) ? '1 : sum_q[W-1:0];
      else                     direct_res = (shifted > SAT_MAX) ? '1 : shifted[W-1:0];
    end
  end

  // Mix FSM state register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Mix FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (snap) state_d = ST_ACC;
      ST_ACC:  if (acc_last) state_d = ST_DIV;
      ST_DIV:  if (!is_norm || (k_q == '0) || div_done) state_d = ST_DONE;
      ST_DONE: if (count == CNT_MAX) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow capture, accumulation, result hold and end-of-period duty update.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      en_sh    <= '0;
      mode_sh  <= MODE_NORM;
      sum_q    <= '0;
      k_q      <= '0;
      ch_q     <= '0;
      result_q <= '0;
      duty_act <= '0;
    end else begin
      if (snap) begin
        duty_sh <= duty_in;
        en_sh   <= en;
        mode_sh <= mix_mode_e'(mode);
        sum_q   <= '0;
        k_q     <= '0;
        ch_q    <= '0;
      end else if (state_q == ST_ACC) begin
        sum_q <= sum_nxt;
        k_q   <= k_nxt;
        ch_q  <= ch_q + 1'b1;
      end
      if ((state_q == ST_DIV) && (state_d == ST_DONE))
        result_q <= (is_norm && (k_q != '0)) ? div_quo[W-1:0] : direct_res;
      if ((state_q == ST_DONE) && (count == CNT_MAX))
        duty_act <= result_q;
    end
  end

  seq_divider #(.SW(SW)) u_div (
    .clk      (sysclk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_nxt),
    .divisor  (SW'(k_nxt)),
    .done     (div_done),
    .quotient (div_quo)
  );

endmodule

// File: tb/tb_pwm_mix_engine.sv
// Bench for pwm_mix_engine: period-level stimulus with mid-period input
// changes, an expected-duty queue per period, and a per-cycle monitor.
module tb_pwm_mix_engine;
  import pwm_mix_pkg::*;

  localparam int N_CH = 4;
  localparam int W    = 6;
  localparam int PER  = 64;

  logic              sysclk = 1'b0;
  logic              rst_n;
  logic [N_CH*W-1:0] duty_in;
  logic [N_CH-1:0]   en;
  logic [1:0]        mode;
  logic              pwm;
  logic [W-1:0]      duty_act;
  logic              period_start;
  logic              busy;
  mix_state_e        fsm_state;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int mcnt;

  // Clock.
  always #5 sysclk = ~sysclk;

  pwm_mix_engine #(.N_CH(N_CH), .W(W)) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .duty_in      (duty_in),
    .en           (en),
    .mode         (mode),
    .pwm          (pwm),
    .duty_act     (duty_act),
    .period_start (period_start),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  // Reference position within the PWM period.
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) mcnt <= 0;
    else        mcnt <= (mcnt + 1) % PER;
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected duty from the mixing rules, using plain integer arithmetic.
  function automatic logic [W-1:0] model_duty(input logic [N_CH*W-1:0] d,
                                              input logic [N_CH-1:0] e,
                                              input logic [1:0] m);
    int sum = 0;
    int k = 0;
    int v;
    int s;
    for (int i = 0; i < N_CH; i++)
      if (e[i]) begin
        sum += int'(d[i*W +: W]);
        k++;
      end
    if (k == 0) return '0;
    case (m)
      2'd1: v = sum;
      2'd2: begin
        s = (k == 1) ? 0 : (k == 2) ? 1 : (k <= 4) ? 2 : (k <= 8) ? 3 : 4;
        v = sum >> s;
      end
      default: v = sum / k;
    endcase
    if (v > PER - 1) v = PER - 1;
    return W'(v);
  endfunction

  function automatic logic [N_CH*W-1:0] pack(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Monitor: one expected duty per period, checked every cycle of that period.
  logic [W-1:0] cur_exp;
  bit started = 1'b0;
  int hi = 0;
  always @(negedge sysclk) begin
    if (!rst_n) begin
      started = 1'b0;
    end else begin
      check("period_start", period_start, mcnt == 0);
      check("busy", busy, mcnt != 0);
      if (period_start) begin
        if (started) check("high_cycles", hi, cur_exp);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty: got no expected duty, required one (t=%0t)", $time);
          cur_exp = '0;
        end else begin
          cur_exp = exp_q.pop_front();
        end
        hi = 0;
        started = 1'b1;
      end
      if (started) begin
        check("duty_act", duty_act, cur_exp);
        check("pwm", pwm, mcnt < int'(cur_exp));
        if (pwm) hi++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // One period: inputs valid at the snapshot edge, replaced after chg cycles.
  task automatic run_period(input logic [N_CH*W-1:0] d, input logic [N_CH-1:0] e,
                            input logic [1:0] m, input int chg,
                            input logic [N_CH*W-1:0] d2, input logic [N_CH-1:0] e2,
                            input logic [1:0] m2);
    duty_in = d;
    en      = e;
    mode    = m;
    exp_q.push_back(model_duty(d, e, m));
    tick(chg);
    duty_in = d2;
    en      = e2;
    mode    = m2;
    tick(PER - chg);
  endtask

  task automatic run_dir(input logic [N_CH*W-1:0] d, input logic [N_CH-1:0] e,
                         input logic [1:0] m);
    run_period(d, e, m, $urandom_range(1, PER - 1),
               pack($urandom_range(0, 63), $urandom_range(0, 63),
                    $urandom_range(0, 63), $urandom_range(0, 63)),
               N_CH'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm"}, pwm, 0);
    check({tag, "_duty_act"}, duty_act, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_period_start"}, period_start, 1);
    check({tag, "_state"}, int'(fsm_state), int'(ST_IDLE));
  endtask

  // Asynchronous reset c cycles into a period, then a clean restart.
  task automatic reset_at(input int c, input logic [N_CH*W-1:0] d,
                          input logic [N_CH-1:0] e, input logic [1:0] m);
    duty_in = d;
    en      = e;
    mode    = m;
    exp_q.push_back(model_duty(d, e, m));
    tick(c);
    rst_n = 1'b0;
    #2;
    check_reset_outputs($sformatf("rst_at_%0d", c));
    tick(2);
    exp_q.delete();
    exp_q.push_back('0);
    rst_n = 1'b1;
  endtask

  // Stimulus.
  initial begin
    rst_n   = 1'b0;
    duty_in = '0;
    en      = '0;
    mode    = '0;
    tick(3);
    check_reset_outputs("por");
    exp_q.push_back('0);
    rst_n = 1'b1;

    // Single channel, NORM.
    repeat (3) run_dir(pack(40, 0, 0, 0), 4'b0001, 2'd0);
    // Three channels across modes.
    for (int m = 0; m < 3; m++) repeat (2) run_dir(pack(30, 20, 10, 0), 4'b0111, 2'(m));
    // All channels at full scale.
    repeat (2) run_dir(pack(63, 63, 63, 63), 4'b1111, 2'd1);
    repeat (2) run_dir(pack(63, 63, 63, 63), 4'b1111, 2'd2);
    // No channel enabled.
    for (int m = 0; m < 4; m++) run_dir(pack(50, 60, 33, 12), 4'b0000, 2'(m));
    // Reserved mode code.
    run_dir(pack(7, 50, 0, 33), 4'b1011, 2'd3);
    // Mid-period change only takes effect at the next snapshot.
    run_period(pack(40, 0, 0, 0), 4'b0001, 2'd0, 10, pack(10, 0, 0, 0), 4'b0001, 2'd0);
    run_dir(pack(10, 0, 0, 0), 4'b0001, 2'd0);
    run_dir(pack(10, 0, 0, 0), 4'b0001, 2'd0);
    // Resets in the middle of a computation.
    reset_at(30, pack(50, 0, 0, 0), 4'b0001, 2'd0);
    repeat (2) run_dir(pack(45, 27, 3, 60), 4'b1111, 2'd0);
    reset_at(8, pack(20, 40, 0, 0), 4'b0011, 2'd0);
    run_dir(pack(20, 40, 0, 0), 4'b0011, 2'd0);
    // Randomized periods.
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 5) == 0)
        run_dir(pack(63, 63, 63, 63), N_CH'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      else
        run_dir(pack($urandom_range(0, 63), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 63)),
                N_CH'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    // Trailing periods so the last random result is observed.
    repeat (2) run_dir(pack(1, 2, 3, 4), 4'b1111, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
